// File: rtl/seg7_to_hex_capture_pkg.sv
// Shared definitions for the seven-segment capture block.
//   DEFAULT_STABLE_CYCLES : default sample count that makes a window stable
//   SEG_PATTERN           : active-low segment patterns for hex digits 0..F,
//                           bit 6 = segment a ... bit 0 = segment g
//   state_t               : capture FSM state encoding
//   an_is_one_hot_low     : true when exactly one digit enable is asserted
//   an_digit_index        : index of the asserted digit enable
package seg7_to_hex_capture_pkg;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  typedef enum logic [0:0] {
    TRACK    = 1'b0,
    CAPTURED = 1'b1
  } state_t;

  function automatic logic an_is_one_hot_low(input logic [3:0] an_n);
    return (an_n == 4'b1110) || (an_n == 4'b1101) ||
           (an_n == 4'b1011) || (an_n == 4'b0111);
  endfunction

  function automatic logic [1:0] an_digit_index(input logic [3:0] an_n);
    logic [1:0] idx;
    case (an_n)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to hex decoder.
//   seg_n : active-low segment pattern, seg_n[6]=a ... seg_n[0]=g
//   hex   : decoded digit value (0 when the pattern is illegal)
//   legal : high when seg_n matches one of the 16 hex patterns
module seg7_decode
  import seg7_to_hex_capture_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] hex,
  output logic       legal
);

  always_comb begin
    hex   = '0;
    legal = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg_n == SEG_PATTERN[i]) begin
        hex   = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_to_hex_capture.sv
// Captures the digits shown on a 4-digit multiplexed seven-segment display.
// A {seg_n, an_n} sample must hold for STABLE_CYCLES consecutive samples
// before it is acted on once; held inputs never act again.
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset
//   seg_n       : active-low segments, seg_n[6]=a ... seg_n[0]=g
//   an_n        : active-low digit enables, an_n[i]=0 selects digit i
//   hex_out     : captured digits, nibble i = hex_out[4i+3:4i]
//   digit_valid : bit i set while nibble i holds a legally decoded digit
//   frame_valid : one-cycle pulse once all four digits have been captured
//   seg_err     : one-cycle pulse on an illegal stable pattern or enable
module seg7_to_hex_capture
  import seg7_to_hex_capture_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] hex_out,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        seg_err
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [10:0] sample_q;
  logic [10:0] prev_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_next;
  state_t      state_q;
  state_t      state_next;
  logic [3:0]  mask_q;

  logic        changed;
  logic        fire;
  logic [6:0]  win_seg;
  logic [3:0]  win_an;
  logic [3:0]  dec_hex;
  logic        dec_legal;
  logic [1:0]  idx;

  logic [15:0] hex_d;
  logic [3:0]  dv_d;
  logic [3:0]  mask_d;
  logic        frame_d;
  logic        err_d;

  assign win_seg = sample_q[10:4];
  assign win_an  = sample_q[3:0];

  seg7_decode u_decode (
    .seg_n (win_seg),
    .hex   (dec_hex),
    .legal (dec_legal)
  );

  // Stability tracking compares the two newest registered samples, so the
  // window completes STABLE_CYCLES+1 edges after the inputs change.
  // A change seen in CAPTURED can complete a new window immediately when
  // STABLE_CYCLES is 1, hence the changed term in fire.
  always_comb begin
    changed  = (sample_q != prev_q);
    cnt_next = cnt_q;
    if (changed) begin
      cnt_next = 8'd1;
    end else if (cnt_q != 8'hFF) begin
      cnt_next = cnt_q + 8'd1;
    end
    fire = ((state_q == TRACK) || changed) && (cnt_next == STABLE_CNT);

    state_next = state_q;
    if (fire) begin
      state_next = CAPTURED;
    end else if (changed) begin
      state_next = TRACK;
    end
  end

  always_comb begin
    hex_d   = hex_out;
    dv_d    = digit_valid;
    mask_d  = mask_q;
    frame_d = 1'b0;
    err_d   = 1'b0;
    idx     = an_digit_index(win_an);
    if (fire && (win_an != 4'b1111)) begin
      if (an_is_one_hot_low(win_an)) begin
        if (dec_legal) begin
          hex_d[{idx, 2'b00} +: 4] = dec_hex;
          dv_d[idx]                = 1'b1;
          mask_d[idx]              = 1'b1;
          if (mask_d == 4'b1111) begin
            frame_d = 1'b1;
            mask_d  = '0;
          end
        end else begin
          err_d     = 1'b1;
          dv_d[idx] = 1'b0;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q    <= '1;
      prev_q      <= '1;
      cnt_q       <= '0;
      state_q     <= TRACK;
      mask_q      <= '0;
      hex_out     <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
    end else begin
      sample_q    <= {seg_n, an_n};
      prev_q      <= sample_q;
      cnt_q       <= cnt_next;
      state_q     <= state_next;
      mask_q      <= mask_d;
      hex_out     <= hex_d;
      digit_valid <= dv_d;
      frame_valid <= frame_d;
      seg_err     <= err_d;
    end
  end

endmodule

// File: tb/tb_seg7_to_hex_capture.sv
module tb_seg7_to_hex_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] hex_out;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        seg_err;

  int checks   = 0;
  int failures = 0;

  logic [15:0] hex_h [1:16];
  logic [3:0]  dv_h  [1:16];
  logic        err_h [1:16];
  logic        fv_h  [1:16];
  int          n_err;
  int          n_fv;

  // Hand-written active-low patterns for 0..F (a..g, MSB = a).
  logic [6:0] pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg7_to_hex_capture #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .seg_err     (seg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n edges, sampling outputs 1 time unit after each rising edge.
  task automatic run(input int n);
    n_err = 0;
    n_fv  = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      hex_h[k] = hex_out;
      dv_h[k]  = digit_valid;
      err_h[k] = seg_err;
      fv_h[k]  = frame_valid;
      n_err += int'(seg_err);
      n_fv  += int'(frame_valid);
    end
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
    seg_n = s;
    an_n  = a;
    run(n);
  endtask

  initial begin
    logic all_dv0;
    reset = 1'b1;
    seg_n = 7'b1111111;
    an_n  = 4'b1111;
    run(3);
    check_eq("rst_hex", hex_out, 16'h0000);
    check_eq("rst_dv", 16'(digit_valid), 16'h0000);
    check_eq("rst_fv", 16'(frame_valid), 16'h0000);
    check_eq("rst_err", 16'(seg_err), 16'h0000);
    reset = 1'b0;
    run(2);

    // Digit 0 = 2, capture visible after edge E+5 only.
    hold(7'b0010010, 4'b1110, 10);
    check_eq("t1_dv_e4", 16'(dv_h[4]), 16'h0000);
    check_eq("t1_dv_e5", 16'(dv_h[5]), 16'h0001);
    check_eq("t1_hex_e5", hex_h[5], 16'h0002);
    check_eq("t1_hex_e10", hex_h[10], 16'h0002);
    check_eq("t1_err", 16'(n_err), 16'd0);
    check_eq("t1_fv", 16'(n_fv), 16'd0);

    // Digits 1, A, 7, F; frame pulse with the digit-3 capture.
    hold(7'b1001111, 4'b1110, 6);
    check_eq("t2_fv_d0", 16'(n_fv), 16'd0);
    hold(7'b0001000, 4'b1101, 6);
    check_eq("t2_fv_d1", 16'(n_fv), 16'd0);
    hold(7'b0001111, 4'b1011, 6);
    check_eq("t2_fv_d2", 16'(n_fv), 16'd0);
    hold(7'b0111000, 4'b0111, 6);
    check_eq("t2_fv_cnt", 16'(n_fv), 16'd1);
    check_eq("t2_fv_e5", 16'(fv_h[5]), 16'h0001);
    check_eq("t2_hex", hex_out, 16'hF7A1);
    check_eq("t2_dv", 16'(digit_valid), 16'h000F);

    // Three-sample hold never captures; blank window does nothing.
    hold(7'b0000000, 4'b1011, 3);
    check_eq("t3_short_err", 16'(n_err), 16'd0);
    hold(7'b1111111, 4'b1111, 8);
    check_eq("t3_hex", hex_out, 16'hF7A1);
    check_eq("t3_dv", 16'(digit_valid), 16'h000F);
    check_eq("t3_err", 16'(n_err), 16'd0);

    // Illegal pattern on digit 1.
    hold(7'b1111111, 4'b1101, 10);
    check_eq("t4_err_cnt", 16'(n_err), 16'd1);
    check_eq("t4_err_e5", 16'(err_h[5]), 16'h0001);
    check_eq("t4_dv", 16'(digit_valid), 16'h000D);
    check_eq("t4_hex", hex_out, 16'hF7A1);
    // Two enables at once.
    hold(7'b0000001, 4'b1100, 10);
    check_eq("t4b_err_cnt", 16'(n_err), 16'd1);
    check_eq("t4b_dv", 16'(digit_valid), 16'h000D);
    check_eq("t4b_hex", hex_out, 16'hF7A1);
    // Blank enables with a legal pattern.
    hold(7'b0000110, 4'b1111, 8);
    check_eq("t4c_err", 16'(n_err), 16'd0);
    check_eq("t4c_hex", hex_out, 16'hF7A1);
    check_eq("t4c_dv", 16'(digit_valid), 16'h000D);

    // Reset two cycles into a stable window.
    seg_n = 7'b0000110;
    an_n  = 4'b1110;
    run(2);
    reset = 1'b1;
    run(1);
    check_eq("t5_hex", hex_out, 16'h0000);
    check_eq("t5_dv", 16'(digit_valid), 16'h0000);
    check_eq("t5_fv", 16'(frame_valid), 16'h0000);
    check_eq("t5_err", 16'(seg_err), 16'h0000);
    reset = 1'b0;
    run(6);
    check_eq("t5_dv_e4", 16'(dv_h[4]), 16'h0000);
    check_eq("t5_dv_e5", 16'(dv_h[5]), 16'h0001);
    check_eq("t5_hex_e5", hex_h[5], 16'h0003);

    // All sixteen patterns on digit 0.
    for (int i = 0; i < 16; i++) begin
      hold(pat[i], 4'b1110, 6);
      all_dv0 = 1'b1;
      for (int k = 1; k <= 6; k++) all_dv0 &= dv_h[k][0];
      check_eq($sformatf("t6_hex_%0d", i), 16'(hex_h[6][3:0]), 16'(i));
      check_eq($sformatf("t6_dv0_%0d", i), 16'(all_dv0), 16'h0001);
    end
    check_eq("t6_err", 16'(n_err), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
